// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: steps {a,b,c} through all eight vectors, waits for the
// block under test to settle, samples y into a table and compares it against a golden table.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       ack,
  input  logic [7:0] expected,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic [7:0] mismatch_mask,
  output logic       mismatch
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] exp_q, exp_d;
  logic [7:0] table_q, table_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] mask_q, mask_d;
  logic       mm_q, mm_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    table_d = table_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          exp_d   = expected;
          table_d = '0;
          idx_d   = '0;
          cnt_d   = CNT_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
          table_d = '0;
          idx_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SAMPLE: begin
        // Abort wins over the sample write and the index advance.
        if (abort) begin
          state_d = IDLE;
          table_d = '0;
          idx_d   = '0;
        end else begin
          table_d[idx_q] = y;
          if (idx_q == 3'd7) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            cnt_d   = CNT_LOAD;
            state_d = SETTLE;
          end
        end
      end
      DONE: begin
        if (ack) begin
          state_d = IDLE;
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
    mask_d = done_d ? (table_d ^ exp_d) : '0;
    mm_d   = |mask_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      table_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mask_q  <= '0;
      mm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mask_q  <= mask_d;
      mm_q    <= mm_d;
    end
  end

  // idx rests at 0 in IDLE and at 7 in DONE, so it doubles as the stimulus register.
  assign a             = idx_q[2];
  assign b             = idx_q[1];
  assign c             = idx_q[0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign table_out     = table_q;
  assign mismatch_mask = mask_q;
  assign mismatch      = mm_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: one instance with SETTLE_CYCLES=1 and
// one with SETTLE_CYCLES=3, each driving its own model of the block under test.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] expected = 8'h00;

  logic       y1, a1, b1, c1, busy1, done1, mm1;
  logic [7:0] table1, mask1;
  logic       y3, a3, b3, c3, busy3, done3, mm3;
  logic [7:0] table3, mask3;
  logic [2:0] abc1, abc3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign y1   = (~a1 & ~b1 & ~c1) | (a1 & ~b1 & ~c1) | (a1 & ~b1 & c1);
  assign y3   = (~a3 & ~b3 & ~c3) | (a3 & ~b3 & ~c3) | (a3 & ~b3 & c3);
  assign abc1 = {a1, b1, c1};
  assign abc3 = {a3, b3, c3};

  truth_table_sweeper #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .ack(ack),
    .expected(expected), .y(y1), .a(a1), .b(b1), .c(c1), .busy(busy1),
    .done(done1), .table_out(table1), .mismatch_mask(mask1), .mismatch(mm1)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .ack(ack),
    .expected(expected), .y(y3), .a(a3), .b(b3), .c(c3), .busy(busy3),
    .done(done3), .table_out(table3), .mismatch_mask(mask3), .mismatch(mm3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; start = 1'b0; abort = 1'b0; ack = 1'b0;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; abort = 1'b0; ack = 1'b1;
    tick;
    reset = 1'b0; start = 1'b0; ack = 1'b0;
    checks++; if (abc1 !== 3'b000) begin errors++; $display("FAIL reset_abc got %b want 000", abc1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done1); end
    checks++; if (table1 !== 8'h00) begin errors++; $display("FAIL reset_table got %h want 00", table1); end
    checks++; if (mask1 !== 8'h00) begin errors++; $display("FAIL reset_mask got %h want 00", mask1); end
    checks++; if (mm1 !== 1'b0) begin errors++; $display("FAIL reset_mismatch got %b want 0", mm1); end
    checks++; if ({busy3, done3, table3} !== 10'd0) begin errors++; $display("FAIL reset_dut3 got %b_%b_%h want 0_0_00", busy3, done3, table3); end
    tick;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_idle_hold got busy %b want 0", busy1); end
  endtask

  task automatic test_nominal;
    do_reset;
    expected = 8'h31; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick;
      checks++; if (abc1 !== 3'(i / 2)) begin errors++; $display("FAIL nom_abc[%0d] got %b want %b", i, abc1, 3'(i / 2)); end
      checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL nom_busy[%0d] got busy %b done %b want 1 0", i, busy1, done1); end
    end
    tick;
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL nom_done got %b want 1", done1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL nom_busy_end got %b want 0", busy1); end
    checks++; if (table1 !== 8'h31) begin errors++; $display("FAIL nom_table got %h want 31", table1); end
    checks++; if (mask1 !== 8'h00 || mm1 !== 1'b0) begin errors++; $display("FAIL nom_mask got %h/%b want 00/0", mask1, mm1); end
    checks++; if (abc1 !== 3'b111) begin errors++; $display("FAIL nom_abc_done got %b want 111", abc1); end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++; if (done1 !== 1'b1 || table1 !== 8'h31) begin errors++; $display("FAIL nom_abort_in_done got %b/%h want 1/31", done1, table1); end
    ack = 1'b1;
    tick;
    ack = 1'b0;
    checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL nom_ack got done %b busy %b want 0 0", done1, busy1); end
    checks++; if (abc1 !== 3'b000) begin errors++; $display("FAIL nom_idle_abc got %b want 000", abc1); end
    checks++; if (table1 !== 8'h31) begin errors++; $display("FAIL nom_idle_table got %h want 31", table1); end
  endtask

  task automatic test_mismatch;
    do_reset;
    expected = 8'h30; start = 1'b1;
    tick;
    start = 1'b0; expected = 8'hFF;
    repeat (16) tick;
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL mm_done got %b want 1", done1); end
    checks++; if (table1 !== 8'h31) begin errors++; $display("FAIL mm_table got %h want 31", table1); end
    checks++; if (mask1 !== 8'h01) begin errors++; $display("FAIL mm_mask got %h want 01", mask1); end
    checks++; if (mm1 !== 1'b1) begin errors++; $display("FAIL mm_flag got %b want 1", mm1); end
    reset = 1'b1; ack = 1'b1;
    tick;
    reset = 1'b0; ack = 1'b0;
    checks++; if ({done1, busy1, abc1, table1, mask1, mm1} !== 22'd0) begin errors++; $display("FAIL mm_reset_in_done got %b %b %b %h %h %b want all 0", done1, busy1, abc1, table1, mask1, mm1); end
  endtask

  task automatic test_settle_stretch;
    do_reset;
    expected = 8'h31; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) tick;
      checks++; if (abc3 !== 3'(i / 4)) begin errors++; $display("FAIL s3_abc[%0d] got %b want %b", i, abc3, 3'(i / 4)); end
      checks++; if (busy3 !== 1'b1 || done3 !== 1'b0) begin errors++; $display("FAIL s3_busy[%0d] got busy %b done %b want 1 0", i, busy3, done3); end
    end
    tick;
    checks++; if (done3 !== 1'b1) begin errors++; $display("FAIL s3_done got %b want 1", done3); end
    checks++; if (table3 !== 8'h31 || mm3 !== 1'b0) begin errors++; $display("FAIL s3_table got %h/%b want 31/0", table3, mm3); end
    ack = 1'b1;
    tick;
    ack = 1'b0;
    checks++; if (done3 !== 1'b0) begin errors++; $display("FAIL s3_ack got %b want 0", done3); end
  endtask

  task automatic test_abort;
    do_reset;
    expected = 8'h31; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    checks++; if (abc1 !== 3'd4 || busy1 !== 1'b1) begin errors++; $display("FAIL ab_pre got %b/%b want 100/1", abc1, busy1); end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin errors++; $display("FAIL ab_idle got busy %b done %b want 0 0", busy1, done1); end
    checks++; if (table1 !== 8'h00) begin errors++; $display("FAIL ab_table got %h want 00", table1); end
    checks++; if (abc1 !== 3'b000) begin errors++; $display("FAIL ab_abc got %b want 000", abc1); end
    for (int i = 0; i < 20; i++) begin
      tick;
      checks++; if (done1 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL ab_quiet[%0d] got done %b busy %b want 0 0", i, done1, busy1); end
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (16) tick;
    checks++; if (done1 !== 1'b1 || table1 !== 8'h31) begin errors++; $display("FAIL ab_restart got %b/%h want 1/31", done1, table1); end
    ack = 1'b1;
    tick;
    ack = 1'b0;
  endtask

  task automatic test_back_to_back;
    do_reset;
    expected = 8'h31; start = 1'b1;
    tick;
    for (int i = 1; i < 16; i++) begin
      tick;
      checks++; if (abc1 !== 3'(i / 2) || busy1 !== 1'b1) begin errors++; $display("FAIL hs_abc[%0d] got %b/%b want %b/1", i, abc1, busy1, 3'(i / 2)); end
    end
    tick;
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL hs_done got %b want 1", done1); end
    tick;
    checks++; if (done1 !== 1'b1 || abc1 !== 3'b111) begin errors++; $display("FAIL hs_hold got %b/%b want 1/111", done1, abc1); end
    ack = 1'b1;
    tick;
    checks++; if (done1 !== 1'b0 || busy1 !== 1'b0 || abc1 !== 3'b000) begin errors++; $display("FAIL hs_ack got %b/%b/%b want 0/0/000", done1, busy1, abc1); end
    start = 1'b0; ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL hs_idle[%0d] got %b want 0", i, busy1); end
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++; if (busy1 !== 1'b1 || abc1 !== 3'b000) begin errors++; $display("FAIL hs_new got %b/%b want 1/000", busy1, abc1); end
    repeat (16) tick;
    ack = 1'b1;
    tick;
    ack = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    expected = 8'h31; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (10) tick;
    checks++; if (abc1 !== 3'd5) begin errors++; $display("FAIL rm_pre got %b want 101", abc1); end
    reset = 1'b1; start = 1'b1; abort = 1'b1; ack = 1'b1;
    tick;
    reset = 1'b0; start = 1'b0; abort = 1'b0; ack = 1'b0;
    checks++; if ({done1, busy1, abc1, table1, mask1, mm1} !== 22'd0) begin errors++; $display("FAIL rm_reset got %b %b %b %h %h %b want all 0", done1, busy1, abc1, table1, mask1, mm1); end
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick;
      checks++; if (abc1 !== 3'(i / 2)) begin errors++; $display("FAIL rm_abc[%0d] got %b want %b", i, abc1, 3'(i / 2)); end
    end
    tick;
    checks++; if (done1 !== 1'b1 || table1 !== 8'h31) begin errors++; $display("FAIL rm_done got %b/%h want 1/31", done1, table1); end
  endtask

  initial begin
    tick;
    test_reset;
    test_nominal;
    test_mismatch;
    test_settle_stretch;
    test_abort;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter SHALL be: SETTLE_CYCLES, default 1, the number of cycles each input vector is held before y is sampled; legal range is 1..15.
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port reset SHALL be: input, 1 bit, synchronous, active-high.
REQ-004 Port start SHALL be: input, 1 bit, sweep request; sampled only in IDLE.
REQ-005 Port abort SHALL be: input, 1 bit, cancels a sweep in progress.
REQ-006 Port ack SHALL be: input, 1 bit, consumer acknowledge of a result.
REQ-007 Port expected SHALL be: input, 8 bits, golden truth table; bit i = expected y for vector i.
REQ-008 Port y SHALL be: input, 1 bit, output of the 3-input combinational block under test.
REQ-009 Ports a, b, c SHALL be: outputs, 1 bit each, registered stimulus to the block under test.
REQ-010 Port busy SHALL be: output, 1 bit, high in SETTLE or SAMPLE.
REQ-011 Port done SHALL be: output, 1 bit, high in DONE.
REQ-012 Port table_out SHALL be: output, 8 bits, captured truth table; bit i = y sampled for vector i.
REQ-013 Port mismatch_mask SHALL be: output, 8 bits, table_out XOR captured expected; valid while done.
REQ-014 Port mismatch SHALL be: output, 1 bit, OR-reduction of mismatch_mask; valid while done.

Function
REQ-015 FSM states SHALL be exactly IDLE, SETTLE, SAMPLE and DONE.
REQ-016 Vector index idx SHALL be 3 bits and SHALL drive {a,b,c} = idx, with a as the MSB.
REQ-017 IDLE with start=1 SHALL at that edge: capture expected, clear table_out, set idx=0, load the settle counter, and go to SETTLE.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-019 SAMPLE SHALL last 1 cycle; at its closing edge y is written to table_out[idx].
REQ-020 After a SAMPLE with idx<7, the FSM SHALL increment idx and return to SETTLE.
REQ-021 After a SAMPLE with idx=7, the FSM SHALL go to DONE; idx SHALL NOT wrap to 0 inside a sweep.
REQ-022 Latency: start sampled at edge k SHALL give done=1 after edge k+8*(SETTLE_CYCLES+1).
REQ-023 Each vector SHALL occupy SETTLE_CYCLES+1 cycles.
REQ-024 DONE SHALL hold done, table_out and mismatch_mask stable until ack=1, then go to IDLE at the next edge.
REQ-025 start SHALL be ignored in SETTLE, SAMPLE and DONE.
REQ-026 start=1 together with ack=1 in DONE SHALL return the FSM to IDLE only; start must be reasserted to begin a new sweep.
REQ-027 abort=1 in SETTLE or SAMPLE SHALL return the FSM to IDLE at the next edge: done is not asserted and table_out is cleared to 0.
REQ-028 abort SHALL have priority over sample completion in the same cycle.
REQ-029 abort SHALL be ignored in IDLE and DONE.
REQ-030 In IDLE, a=b=c=0; in DONE, {a,b,c} SHALL hold 3'b111.
REQ-031 table_out SHALL NOT change outside SAMPLE-closing edges, start acceptance and abort.

Reset
REQ-032 reset=1 at a rising edge SHALL force: state IDLE, idx=0, a=b=c=0, busy=0, done=0, table_out=0, mismatch_mask=0, mismatch=0, captured expected=0.
REQ-033 reset SHALL override start, abort and ack in the same cycle, including mid-sweep and in DONE.

Verification
REQ-034 Nominal sweep: SETTLE_CYCLES=1, block under test is y = ~a&~b&~c | a&~b&~c | a&~b&c, expected=8'h31, start pulsed at edge k -> done=1 after edge k+16, table_out=8'h31, mismatch=0, busy high for 16 cycles.
REQ-035 Mismatch: same as REQ-034 with expected=8'h30 -> mismatch_mask=8'h01, mismatch=1; expected changed during the sweep has no effect.
REQ-036 Settle stretch: SETTLE_CYCLES=3 -> each vector is held 4 cycles, done after edge k+32, stimulus order 000,001,...,111.
REQ-037 Abort: abort asserted in SAMPLE of idx=4 -> IDLE next edge, table_out=0, done never asserted; a fresh start then completes normally.
REQ-038 Handshake: start held high throughout a sweep plus DONE with ack=1 -> exactly one sweep; IDLE after ack, and a new sweep only from a later start in IDLE.
REQ-039 Reset mid-sweep at idx=5 -> all outputs at REQ-032 values at the next edge; start the following cycle -> full 8-vector sweep from idx=0.
